// File: rtl/profile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// profile_dump_sequencer
//
// Runs a state-profiler for a window bounded by cmd_start/cmd_stop, waits for
// the profiler pipeline to settle, then walks the profiler's count-select bus
// and streams every per-state count out over a ready/valid interface. An
// optional final word carries the saturated sum of all counts.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for cmd_start; profiler stopped
//   S_RUN   | profiling window open (prof_start high)
//   S_DRAIN | 2-cycle wait for the profiler's probe/exit latency
//   S_DUMP  | walking prof_sel and emitting the count stream
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   cmd_start   pulse: open a profiling window (IDLE only)
//   cmd_stop    pulse: close the window and start the dump (RUN only)
//   prof_start  registered run/enable level to the profiler
//   prof_sel    profiler count-select (index in DUMP, 0 otherwise)
//   prof_count  profiler count for prof_sel, same-cycle
//   out_valid   result stream valid
//   out_ready   result stream ready
//   out_data    result stream word
//   out_last    marks the final word of the stream
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module profile_dump_sequencer #(
    parameter int NUM_STATES = 8,
    parameter int SEL_W      = 3,
    parameter int EMIT_TOTAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    output logic             prof_start,
    output logic [SEL_W-1:0] prof_sel,
    input  logic [31:0]      prof_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    // index runs to NUM_STATES inclusive (the total-word slot) and one past it
    localparam int IDX_W = $clog2(NUM_STATES + 2);
    localparam logic [IDX_W-1:0] IDX_NUM   = IDX_W'(NUM_STATES);
    localparam logic [IDX_W-1:0] IDX_FINAL = IDX_W'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              drain_q, drain_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [39:0]       total_q, total_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              prof_start_q;

    logic              slot_free;
    logic              handshake;
    logic [31:0]       total_sat;

    assign slot_free = !out_valid_q || out_ready;
    assign handshake = out_valid_q && out_ready;
    assign total_sat = (total_q[39:32] != 8'd0) ? 32'hFFFF_FFFF : total_q[31:0];

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        index_d     = index_q;
        total_d     = total_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // cmd_stop is meaningless here, so start wins a tie implicitly
                if (cmd_start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (cmd_stop) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end

            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DUMP;
                    index_d = '0;
                    total_d = '0;
                end else begin
                    drain_d = 1'b1;
                end
            end

            S_DUMP: begin
                if (handshake && out_last_q) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (slot_free && (index_q < IDX_NUM)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = prof_count;
                    out_last_d  = (EMIT_TOTAL == 0) && (index_q == IDX_FINAL);
                    total_d     = total_q + {8'd0, prof_count};
                    index_d     = index_q + 1'b1;
                end else if (slot_free && (EMIT_TOTAL != 0) && (index_q == IDX_NUM)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = total_sat;
                    out_last_d  = 1'b1;
                    index_d     = index_q + 1'b1;
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            drain_q      <= 1'b0;
            index_q      <= '0;
            total_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            prof_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            index_q      <= index_d;
            total_q      <= total_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            // registered copy of "in RUN" so the profiler sees a clean level
            prof_start_q <= (state_d == S_RUN);
        end
    end

    assign prof_start = prof_start_q;
    assign prof_sel   = (state_q == S_DUMP) ? SEL_W'(index_q) : '0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_profile_dump_sequencer.sv
module tb_profile_dump_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // default instance: 8 states, total word appended
    logic        a_cmd_start, a_cmd_stop, a_prof_start, a_out_valid, a_out_ready;
    logic        a_out_last, a_busy, a_done;
    logic [2:0]  a_prof_sel;
    logic [31:0] a_prof_count, a_out_data;
    logic [31:0] a_tab [8];
    assign a_prof_count = a_tab[a_prof_sel];

    // small instance: 4 states, no total word
    logic        b_cmd_start, b_cmd_stop, b_prof_start, b_out_valid, b_out_ready;
    logic        b_out_last, b_busy, b_done;
    logic [1:0]  b_prof_sel;
    logic [31:0] b_prof_count, b_out_data;
    logic [31:0] b_tab [4];
    assign b_prof_count = b_tab[b_prof_sel];

    profile_dump_sequencer #(.NUM_STATES(8), .SEL_W(3), .EMIT_TOTAL(1)) dut_a (
        .clk(clk), .reset(reset), .cmd_start(a_cmd_start), .cmd_stop(a_cmd_stop),
        .prof_start(a_prof_start), .prof_sel(a_prof_sel), .prof_count(a_prof_count),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .done(a_done));

    profile_dump_sequencer #(.NUM_STATES(4), .SEL_W(2), .EMIT_TOTAL(0)) dut_b (
        .clk(clk), .reset(reset), .cmd_start(b_cmd_start), .cmd_stop(b_cmd_stop),
        .prof_start(b_prof_start), .prof_sel(b_prof_sel), .prof_count(b_prof_count),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .done(b_done));

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- stream monitors ----------------
    logic [31:0] a_words [$];
    logic        a_lasts [$];
    int          a_done_cnt = 0, a_viol = 0;
    logic        a_pv = 1'b0, a_pr = 1'b0, a_pl = 1'b0;
    logic [31:0] a_pd = '0;

    always @(posedge clk) begin
        if (reset) begin
            a_pv <= 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                a_words.push_back(a_out_data);
                a_lasts.push_back(a_out_last);
            end
            if (a_pv && !a_pr && !(a_out_valid && a_out_data == a_pd && a_out_last == a_pl))
                a_viol <= a_viol + 1;
            else if (!a_out_valid && a_out_last)
                a_viol <= a_viol + 1;
            else if ((!a_busy || a_prof_start) && a_prof_sel != 3'd0)
                a_viol <= a_viol + 1;
            if (a_done) a_done_cnt <= a_done_cnt + 1;
            a_pv <= a_out_valid;
            a_pr <= a_out_ready;
            a_pd <= a_out_data;
            a_pl <= a_out_last;
        end
    end

    logic [31:0] b_words [$];
    logic        b_lasts [$];
    int          b_done_cnt = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (b_out_valid && b_out_ready) begin
                b_words.push_back(b_out_data);
                b_lasts.push_back(b_out_last);
            end
            if (b_done) b_done_cnt <= b_done_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_w [$];

    task automatic build_exp_a();
        longint sum = 0;
        exp_w.delete();
        for (int i = 0; i < 8; i++) begin
            exp_w.push_back(a_tab[i]);
            sum += longint'(a_tab[i]);
        end
        exp_w.push_back(sum > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : sum[31:0]);
    endtask

    task automatic build_exp_b();
        exp_w.delete();
        for (int i = 0; i < 4; i++) exp_w.push_back(b_tab[i]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // mode: 0 ready=1, 1 ready pattern 1-0-0-1, 2 random ready,
    //       3 ready=1 plus a cmd_start pulse during the dump
    task automatic run_a(input int stop_at, input int mode, output int ps_cycles, output bit timeout);
        bit seen_done = 1'b0;
        ps_cycles = 0;
        a_cmd_start = 1'b1;
        tick();
        a_cmd_start = 1'b0;
        for (int c = 1; c < stop_at; c++) begin
            if (a_prof_start) ps_cycles++;
            tick();
        end
        if (a_prof_start) ps_cycles++;
        a_cmd_stop = 1'b1;
        tick();
        a_cmd_stop = 1'b0;
        if (a_prof_start) ps_cycles++;
        for (int k = 0; k < 2000 && !seen_done; k++) begin
            case (mode)
                1:       a_out_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       a_out_ready = ($urandom_range(0, 2) != 0);
                default: a_out_ready = 1'b1;
            endcase
            a_cmd_start = (mode == 3) && (k == 4);
            tick();
            if (a_done) seen_done = 1'b1;
        end
        a_cmd_start = 1'b0;
        a_out_ready = 1'b0;
        tick();
        timeout = !seen_done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        a_cmd_start = 1'b1;
        repeat (2) tick();
        a_cmd_start = 1'b0;
        n_cmp++; if (a_prof_start !== 1'b0) begin n_fail++; $display("FAIL reset_prof_start got=%b exp=0", a_prof_start); end
        n_cmp++; if (a_prof_sel !== 3'd0) begin n_fail++; $display("FAIL reset_prof_sel got=%0d exp=0", a_prof_sel); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        n_cmp++; if (a_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
        n_cmp++; if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", a_out_last); end
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", a_done); end
        n_cmp++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b got busy=%b valid=%b exp=0/0", b_busy, b_out_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int base = a_words.size(), dbase = a_done_cnt, vbase = a_viol, ps, got;
        bit to;
        for (int i = 0; i < 8; i++) a_tab[i] = 32'(i * 100);
        build_exp_a();
        run_a(10, 0, ps, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic_done_timeout got=timeout exp=done"); end
        n_cmp++; if (ps !== 10) begin n_fail++; $display("FAIL basic_prof_start_cycles got=%0d exp=10", ps); end
        got = a_words.size() - base;
        n_cmp++; if (got !== exp_w.size()) begin n_fail++; $display("FAIL basic_word_count got=%0d exp=%0d", got, exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got; i++) begin
            n_cmp++; if (a_words[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL basic_word[%0d] got=%0d exp=%0d", i, a_words[base+i], exp_w[i]); end
            n_cmp++; if (a_lasts[base+i] !== (i == exp_w.size() - 1)) begin n_fail++; $display("FAIL basic_last[%0d] got=%b", i, a_lasts[base+i]); end
        end
        n_cmp++; if (a_done_cnt - dbase !== 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", a_done_cnt - dbase); end
        n_cmp++; if (a_viol !== vbase) begin n_fail++; $display("FAIL basic_protocol got=%0d exp=0", a_viol - vbase); end
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got busy=%b exp=0", a_busy); end
    endtask

    task automatic test_stream(input string name, input int iters, input int mode, input bit sat);
        for (int it = 0; it < iters; it++) begin
            int base = a_words.size(), dbase = a_done_cnt, vbase = a_viol, ps, got;
            int stop_at = $urandom_range(2, 25);
            bit to;
            for (int i = 0; i < 8; i++)
                a_tab[i] = sat ? 32'h4000_0000 :
                           (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 5000));
            build_exp_a();
            run_a(stop_at, mode, ps, to);
            n_cmp++; if (to) begin n_fail++; $display("FAIL %s_done_timeout it=%0d", name, it); end
            n_cmp++; if (ps !== stop_at) begin n_fail++; $display("FAIL %s_prof_start_cycles got=%0d exp=%0d", name, ps, stop_at); end
            got = a_words.size() - base;
            n_cmp++; if (got !== exp_w.size()) begin n_fail++; $display("FAIL %s_word_count got=%0d exp=%0d", name, got, exp_w.size()); end
            for (int i = 0; i < exp_w.size() && i < got; i++) begin
                n_cmp++; if (a_words[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL %s_word[%0d] got=%h exp=%h", name, i, a_words[base+i], exp_w[i]); end
                n_cmp++; if (a_lasts[base+i] !== (i == exp_w.size() - 1)) begin n_fail++; $display("FAIL %s_last[%0d] got=%b", name, i, a_lasts[base+i]); end
            end
            n_cmp++; if (a_done_cnt - dbase !== 1) begin n_fail++; $display("FAIL %s_done_pulses got=%0d exp=1", name, a_done_cnt - dbase); end
            n_cmp++; if (a_viol !== vbase) begin n_fail++; $display("FAIL %s_protocol got=%0d exp=0", name, a_viol - vbase); end
        end
    endtask

    task automatic test_commands();
        int base, got, ps;
        bit to, seen;
        a_cmd_stop = 1'b1;
        tick();
        a_cmd_stop = 1'b0;
        tick();
        n_cmp++; if (a_busy !== 1'b0 || a_prof_start !== 1'b0) begin n_fail++; $display("FAIL cmd_stop_idle got busy=%b ps=%b exp=0/0", a_busy, a_prof_start); end
        a_cmd_start = 1'b1;
        a_cmd_stop  = 1'b1;
        tick();
        a_cmd_start = 1'b0;
        a_cmd_stop  = 1'b0;
        n_cmp++; if (a_busy !== 1'b1 || a_prof_start !== 1'b1) begin n_fail++; $display("FAIL cmd_both_idle got busy=%b ps=%b exp=1/1", a_busy, a_prof_start); end
        repeat (3) tick();
        a_cmd_stop = 1'b1;
        tick();
        a_cmd_stop = 1'b0;
        a_out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (a_done) seen = 1'b1;
        end
        a_out_ready = 1'b0;
        tick();
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL cmd_both_dump got=timeout exp=done"); end

        for (int i = 0; i < 8; i++) a_tab[i] = $urandom_range(1, 1000);
        build_exp_a();
        base = a_words.size();
        run_a(6, 3, ps, to);
        repeat (3) tick();
        got = a_words.size() - base;
        n_cmp++; if (to) begin n_fail++; $display("FAIL cmd_start_dump_timeout got=timeout exp=done"); end
        n_cmp++; if (got !== exp_w.size()) begin n_fail++; $display("FAIL cmd_start_dump_count got=%0d exp=%0d", got, exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got; i++) begin
            n_cmp++; if (a_words[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL cmd_start_dump_word[%0d] got=%0d exp=%0d", i, a_words[base+i], exp_w[i]); end
        end
        n_cmp++; if (a_busy !== 1'b0 || a_prof_start !== 1'b0) begin n_fail++; $display("FAIL cmd_start_dump_restart got busy=%b ps=%b exp=0/0", a_busy, a_prof_start); end
    endtask

    task automatic test_reset_mid_dump();
        int base = a_words.size(), dbase, vbase, ps, got;
        bit to, hit = 1'b0;
        for (int i = 0; i < 8; i++) a_tab[i] = $urandom_range(10, 90000);
        a_cmd_start = 1'b1;
        tick();
        a_cmd_start = 1'b0;
        repeat (4) tick();
        a_cmd_stop = 1'b1;
        tick();
        a_cmd_stop = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 100 && !hit; k++) begin
            tick();
            if (a_words.size() - base >= 3) hit = 1'b1;
        end
        a_out_ready = 1'b0;
        repeat (2) tick();
        n_cmp++; if (!hit || a_out_valid !== 1'b1 || a_out_data !== a_tab[3]) begin n_fail++; $display("FAIL rst_mid_word3_pending got valid=%b data=%0d exp=1/%0d", a_out_valid, a_out_data, a_tab[3]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear got valid=%b busy=%b exp=0/0", a_out_valid, a_busy); end
        n_cmp++; if (a_out_last !== 1'b0 || a_prof_sel !== 3'd0 || a_out_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_regs got last=%b sel=%0d data=%0d exp=0/0/0", a_out_last, a_prof_sel, a_out_data); end
        a_out_ready = 1'b1;
        repeat (4) tick();
        a_out_ready = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resume got valid=%b busy=%b exp=0/0", a_out_valid, a_busy); end
        base  = a_words.size();
        dbase = a_done_cnt;
        vbase = a_viol;
        build_exp_a();
        run_a(5, 2, ps, to);
        got = a_words.size() - base;
        n_cmp++; if (to || got !== exp_w.size()) begin n_fail++; $display("FAIL rst_mid_rerun_count got=%0d exp=%0d", got, exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got; i++) begin
            n_cmp++; if (a_words[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL rst_mid_rerun_word[%0d] got=%0d exp=%0d", i, a_words[base+i], exp_w[i]); end
        end
        n_cmp++; if (a_done_cnt - dbase !== 1 || a_viol !== vbase) begin n_fail++; $display("FAIL rst_mid_rerun_done got done=%0d viol=%0d exp=1/0", a_done_cnt - dbase, a_viol - vbase); end
    endtask

    task automatic test_no_total();
        for (int it = 0; it < 3; it++) begin
            int base = b_words.size(), dbase = b_done_cnt, got;
            bit seen = 1'b0;
            for (int i = 0; i < 4; i++) b_tab[i] = $urandom;
            build_exp_b();
            b_cmd_start = 1'b1;
            tick();
            b_cmd_start = 1'b0;
            repeat ($urandom_range(1, 8)) tick();
            b_cmd_stop = 1'b1;
            tick();
            b_cmd_stop = 1'b0;
            for (int k = 0; k < 500 && !seen; k++) begin
                b_out_ready = (it == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
                tick();
                if (b_done) seen = 1'b1;
            end
            b_out_ready = 1'b0;
            repeat (3) tick();
            got = b_words.size() - base;
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL no_total_done_timeout it=%0d", it); end
            n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL no_total_count got=%0d exp=4", got); end
            for (int i = 0; i < 4 && i < got; i++) begin
                n_cmp++; if (b_words[base+i] !== exp_w[i]) begin n_fail++; $display("FAIL no_total_word[%0d] got=%h exp=%h", i, b_words[base+i], exp_w[i]); end
                n_cmp++; if (b_lasts[base+i] !== (i == 3)) begin n_fail++; $display("FAIL no_total_last[%0d] got=%b exp=%b", i, b_lasts[base+i], (i == 3)); end
            end
            n_cmp++; if (b_done_cnt - dbase !== 1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL no_total_done got pulses=%0d busy=%b exp=1/0", b_done_cnt - dbase, b_busy); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_cmd_start = 1'b0; a_cmd_stop = 1'b0; a_out_ready = 1'b0;
        b_cmd_start = 1'b0; b_cmd_stop = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) a_tab[i] = '0;
        for (int i = 0; i < 4; i++) b_tab[i] = '0;
        do_reset();
        test_reset();
        test_basic();
        test_stream("backpressure", 3, 1, 1'b0);
        test_stream("saturation", 1, 0, 1'b1);
        test_stream("saturation_bp", 1, 1, 1'b1);
        test_stream("random", 6, 2, 1'b0);
        test_commands();
        test_reset_mid_dump();
        test_no_total();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
